instruction_fetch: RTL and testbench

Instruction sequencer that feeds the control unit and datapath.
- Owns the instruction pointer (IP) and fetches 32-bit instruction words from program memory over a request/grant/read-valid handshake.
- Splits each word into command_group, command and operand fields for the control unit.
- Takes the control unit's branch_select and the ALU condition result back, and selects the next IP.

---
 rtl/instruction_fetch.sv | 160 ++++++++++++++++
 tb/tb_instruction_fetch.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - instruction pointer, program fetch handshake, decode fields and next-IP select
module instruction_fetch #(
  parameter int                  IP_WIDTH    = 8,
  parameter logic [IP_WIDTH-1:0] RESET_IP    = '0,
  parameter int                  COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   enable,
  output logic                   mem_req,
  output logic [IP_WIDTH-1:0]    mem_addr,
  input  logic                   mem_grant,
  input  logic                   mem_rvalid,
  input  logic [31:0]            mem_rdata,
  output logic [2:0]             command_group,
  output logic [2:0]             command,
  output logic [7:0]             arg_a,
  output logic [7:0]             arg_b,
  output logic [7:0]             arg_c,
  output logic                   instr_valid,
  input  logic                   branch_select,
  input  logic                   cond_true,
  input  logic                   stall,
  output logic [IP_WIDTH-1:0]    ip,
  output logic                   running,
  output logic [COUNT_WIDTH-1:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_WAIT    = 3'd2,
    S_DECODE  = 3'd3,
    S_EXECUTE = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [IP_WIDTH-1:0]    ip_q, ip_d;
  logic [COUNT_WIDTH-1:0] retired_q, retired_d;
  logic [2:0]             cg_q, cg_d;
  logic [2:0]             cmd_q, cmd_d;
  logic [7:0]             arg_a_q, arg_a_d;
  logic [7:0]             arg_b_q, arg_b_d;
  logic [7:0]             arg_c_q, arg_c_d;
  logic                   mem_req_q, mem_req_d;
  logic                   instr_valid_q, instr_valid_d;
  logic                   running_q, running_d;

  logic [IP_WIDTH-1:0]    branch_target;
  logic [IP_WIDTH-1:0]    ip_incr;
  logic                   take_branch;

  // IR bits 25:24 carry no field; they are captured nowhere
  logic                   unused_ir_rsvd;
  assign unused_ir_rsvd = ^mem_rdata[25:24];

  // The target is arg_c truncated or zero-extended to the IP width
  assign branch_target = IP_WIDTH'(arg_c_q);
  assign ip_incr       = ip_q + IP_WIDTH'(1);
  assign take_branch   = branch_select & cond_true;

  // Next-state, next-IP, IR capture and registered output decode
  always_comb begin
    state_d   = state_q;
    ip_d      = ip_q;
    retired_d = retired_q;
    cg_d      = cg_q;
    cmd_d     = cmd_q;
    arg_a_d   = arg_a_q;
    arg_b_d   = arg_b_q;
    arg_c_d   = arg_c_q;

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (mem_grant) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // Wait indefinitely for the read data; a late grant is meaningless here
        if (mem_rvalid) begin
          cg_d    = mem_rdata[31:29];
          cmd_d   = mem_rdata[28:26];
          arg_a_d = mem_rdata[23:16];
          arg_b_d = mem_rdata[15:8];
          arg_c_d = mem_rdata[7:0];
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        if (!stall) begin
          ip_d = take_branch ? branch_target : ip_incr;
          if (retired_q != {COUNT_WIDTH{1'b1}}) begin
            retired_d = retired_q + COUNT_WIDTH'(1);
          end
          // enable is only honoured here, so an in-flight instruction always retires
          state_d = enable ? S_FETCH : S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they are registered alongside it
    mem_req_d     = (state_d == S_FETCH);
    instr_valid_d = (state_d == S_DECODE);
    running_d     = (state_d != S_IDLE);
  end

  // State and datapath registers; reset wins over any handshake in flight
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      ip_q          <= RESET_IP;
      retired_q     <= '0;
      cg_q          <= '0;
      cmd_q         <= '0;
      arg_a_q       <= '0;
      arg_b_q       <= '0;
      arg_c_q       <= '0;
      mem_req_q     <= 1'b0;
      instr_valid_q <= 1'b0;
      running_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      ip_q          <= ip_d;
      retired_q     <= retired_d;
      cg_q          <= cg_d;
      cmd_q         <= cmd_d;
      arg_a_q       <= arg_a_d;
      arg_b_q       <= arg_b_d;
      arg_c_q       <= arg_c_d;
      mem_req_q     <= mem_req_d;
      instr_valid_q <= instr_valid_d;
      running_q     <= running_d;
    end
  end

  assign mem_req       = mem_req_q;
  assign mem_addr      = ip_q;
  assign command_group = cg_q;
  assign command       = cmd_q;
  assign arg_a         = arg_a_q;
  assign arg_b         = arg_b_q;
  assign arg_c         = arg_c_q;
  assign instr_valid   = instr_valid_q;
  assign ip            = ip_q;
  assign running       = running_q;
  assign retired       = retired_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - self-checking bench for instruction_fetch
module tb_instruction_fetch;

  localparam int CW = 5;
  localparam int RMAX = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic          mem_req;
  logic [7:0]    mem_addr;
  logic          mem_grant = 1'b0;
  logic          mem_rvalid = 1'b0;
  logic [31:0]   mem_rdata = '0;
  logic [2:0]    command_group;
  logic [2:0]    command;
  logic [7:0]    arg_a;
  logic [7:0]    arg_b;
  logic [7:0]    arg_c;
  logic          instr_valid;
  logic          branch_select = 1'b0;
  logic          cond_true = 1'b0;
  logic          stall = 1'b0;
  logic [7:0]    ip;
  logic          running;
  logic [CW-1:0] retired;

  int checks = 0;
  int errors = 0;
  int model_ip = 0;
  int model_retired = 0;

  instruction_fetch #(.IP_WIDTH(8), .RESET_IP(8'h00), .COUNT_WIDTH(CW)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_grant(mem_grant),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .command_group(command_group), .command(command),
    .arg_a(arg_a), .arg_b(arg_b), .arg_c(arg_c), .instr_valid(instr_valid),
    .branch_select(branch_select), .cond_true(cond_true), .stall(stall),
    .ip(ip), .running(running), .retired(retired)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One instruction from FETCH through retirement, checked against the model.
  task automatic do_instr(input logic [31:0] word, input int gdly, input int rdly,
                          input int nstall, input bit br, input bit cnd, input bit en_after);
    check("fetch_req", int'(mem_req), 1);
    check("fetch_addr", int'(mem_addr), model_ip);
    for (int g = 0; g < gdly; g++) begin
      mem_grant = 1'b0;
      step();
      check("hold_req", int'(mem_req), 1);
      check("hold_addr", int'(mem_addr), model_ip);
    end
    mem_grant = 1'b1;
    step();
    mem_grant = 1'b0;
    enable = en_after;
    check("wait_req", int'(mem_req), 0);
    check("wait_running", int'(running), 1);
    for (int r = 0; r < rdly; r++) begin
      mem_grant = 1'($urandom_range(0, 1));
      step();
      check("wait_idle_valid", int'(instr_valid), 0);
      check("wait_req_low", int'(mem_req), 0);
    end
    mem_grant = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata = word;
    step();
    mem_rvalid = 1'b0;
    mem_rdata = $urandom;
    check("dec_valid", int'(instr_valid), 1);
    check("dec_group", int'(command_group), int'((word >> 29) & 32'h7));
    check("dec_cmd", int'(command), int'((word >> 26) & 32'h7));
    check("dec_arg_a", int'(arg_a), int'((word >> 16) & 32'hff));
    check("dec_arg_b", int'(arg_b), int'((word >> 8) & 32'hff));
    check("dec_arg_c", int'(arg_c), int'(word & 32'hff));
    branch_select = br;
    cond_true = cnd;
    stall = (nstall > 0);
    step();
    check("exec_valid", int'(instr_valid), 0);
    check("exec_ip", int'(ip), model_ip);
    for (int s = 0; s < nstall; s++) begin
      if (s == nstall - 1) stall = 1'b0;
      else stall = 1'b1;
      if (s < nstall - 1) begin
        step();
        check("stall_ip", int'(ip), model_ip);
        check("stall_valid", int'(instr_valid), 0);
      end
    end
    stall = 1'b0;
    step();
    if (br && cnd) model_ip = int'(word & 32'hff);
    else model_ip = (model_ip + 1) % 256;
    if (model_retired < RMAX) model_retired++;
    check("ret_ip", int'(ip), model_ip);
    check("ret_count", int'(retired), model_retired);
    check("ret_valid", int'(instr_valid), 0);
    check("ret_req", int'(mem_req), int'(en_after));
    check("ret_running", int'(running), int'(en_after));
    branch_select = 1'b0;
    cond_true = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    step();
    step();
    check("rst_ip", int'(ip), 0);
    check("rst_req", int'(mem_req), 0);
    check("rst_valid", int'(instr_valid), 0);
    check("rst_running", int'(running), 0);
    check("rst_retired", int'(retired), 0);
    check("rst_group", int'(command_group), 0);
    reset_n = 1'b1;
    step();
    check("idle_stay", int'(running), 0);
    enable = 1'b1;
    step();

    do_instr(32'h24010203, 0, 0, 0, 1'b0, 1'b0, 1'b1);
    do_instr(32'h40000040, 0, 0, 0, 1'b1, 1'b1, 1'b1);
    check("jump_target", int'(ip), 8'h40);
    do_instr(32'h40000010, 0, 0, 0, 1'b1, 1'b0, 1'b1);
    check("jump_not_taken", int'(ip), 8'h41);
    do_instr(32'h400000ff, 0, 0, 0, 1'b1, 1'b1, 1'b1);
    do_instr(32'h0a0b0c0d, 0, 0, 0, 1'b0, 1'b1, 1'b1);
    check("ip_wrap", int'(ip), 0);
    do_instr($urandom, 5, 2, 3, 1'b0, 1'b0, 1'b1);
    do_instr(32'h40000000 | model_ip, 1, 1, 0, 1'b1, 1'b1, 1'b1);
    do_instr($urandom, 0, 3, 0, 1'b0, 1'b0, 1'b0);
    step();
    check("idle_req", int'(mem_req), 0);
    check("idle_running", int'(running), 0);
    step();
    check("idle_hold_ip", int'(ip), model_ip);
    enable = 1'b1;
    step();

    for (int k = 0; k < 40; k++) begin
      do_instr($urandom, $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 2), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'b1);
    end
    check("sat_retired", int'(retired), RMAX);

    mem_grant = 1'b1;
    step();
    mem_grant = 1'b0;
    check("pre_rst_wait", int'(mem_req), 0);
    reset_n = 1'b0;
    enable = 1'b0;
    step();
    reset_n = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata = 32'hffffffff;
    step();
    mem_rvalid = 1'b0;
    check("late_group", int'(command_group), 0);
    check("late_arg_c", int'(arg_c), 0);
    check("late_valid", int'(instr_valid), 0);
    check("late_ip", int'(ip), 0);
    check("late_retired", int'(retired), 0);
    check("late_running", int'(running), 0);
    step();
    check("late_idle", int'(mem_req), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
